// File: rtl/vga_plot_sink.sv
// Pixel-plot framebuffer sink: single-pixel plot and full-screen clear write port,
// continuous 2x pixel-doubled VGA scan-out and a once-per-frame vertical-blank pulse.
module vga_plot_sink #(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter logic [5:0]  CLEAR_COLOUR = 6'b000000,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       plot,
  input  logic [8:0] xIn,
  input  logic [7:0] yIn,
  input  logic [5:0] colourIn,
  input  logic       clear,
  output logic       busy,
  output logic       frameStart,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int unsigned Depth      = WIDTH * HEIGHT;
  localparam int unsigned AddrW      = $clog2(Depth);
  localparam int unsigned HTotal     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

  typedef enum logic [0:0] {StIdle, StClearing} state_e;

  state_e           state_q;
  logic [AddrW-1:0] clr_addr_q;
  logic             busy_q;

  logic [5:0]       mem_q [Depth];
  logic [5:0]       rd_q;
  logic             we;
  logic [AddrW-1:0] waddr;
  logic [AddrW-1:0] raddr;
  logic [AddrW-1:0] plot_addr;
  logic [5:0]       wdata;
  logic             plot_ok;

  logic             pix_en_q;
  logic             vga_clk_q;
  logic             frame_start_q;
  logic [9:0]       h_q;
  logic [9:0]       v_q;
  logic             scan_vis;
  logic             hs_act;
  logic             vs_act;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;
  logic             hs_q;
  logic             vs_q;
  logic             blank_n_q;

  function automatic logic [7:0] expand(input logic [1:0] c);
    return {4{c}};
  endfunction

  // Out-of-range plots are dropped rather than wrapped into the next row.
  assign plot_ok   = (32'(xIn) < WIDTH) && (32'(yIn) < HEIGHT);
  assign plot_addr = AddrW'(32'(yIn) * WIDTH + 32'(xIn));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clear) begin
            state_q    <= StClearing;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        StClearing: begin
          if (32'(clr_addr_q) == Depth - 1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
      endcase
    end
  end

  // A clear owns the write port; a plot coinciding with a clear request is lost.
  always_comb begin
    we    = 1'b0;
    waddr = plot_addr;
    wdata = colourIn;
    if (state_q == StClearing) begin
      we    = 1'b1;
      waddr = clr_addr_q;
      wdata = CLEAR_COLOUR;
    end else if (plot && !clear && plot_ok) begin
      we = 1'b1;
    end
  end

  assign scan_vis = (32'(h_q) < H_VISIBLE) && (32'(v_q) < V_VISIBLE);
  assign raddr    = AddrW'(32'(v_q >> 1) * WIDTH + 32'(h_q >> 1));
  assign hs_act   = (32'(h_q) >= HSyncStart) && (32'(h_q) < HSyncEnd);
  assign vs_act   = (32'(v_q) >= VSyncStart) && (32'(v_q) < VSyncEnd);

  always_ff @(posedge Clock) begin
    if (we) mem_q[waddr] <= wdata;
    if (scan_vis) rd_q <= mem_q[raddr];
  end

  // Counters hold each pixel for two clocks; the RAM read lands in the first,
  // and the output registers capture it on the pixEn edge that ends the second.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      vga_clk_q     <= ~pix_en_q;
      frame_start_q <= 1'b0;
      if (pix_en_q) begin
        if (32'(h_q) == HTotal - 1) begin
          h_q           <= '0;
          frame_start_q <= (32'(v_q) == V_VISIBLE - 1);
          if (32'(v_q) == VTotal - 1) v_q <= '0;
          else                        v_q <= v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
        r_q       <= scan_vis ? expand(rd_q[5:4]) : 8'h00;
        g_q       <= scan_vis ? expand(rd_q[3:2]) : 8'h00;
        b_q       <= scan_vis ? expand(rd_q[1:0]) : 8'h00;
        hs_q      <= ~hs_act;
        vs_q      <= ~vs_act;
        blank_n_q <= scan_vis;
      end
    end
  end

  assign busy        = busy_q;
  assign frameStart  = frame_start_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;

endmodule
